// File: rtl/mem_seq_pkg.sv
// Shared encodings for the IF/MEM byte-port sequencer.
// States, owner codes and request attribute values.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OWN_IF    = 1'b0;
    localparam logic OWN_MEM   = 1'b1;

    localparam logic RW_READ   = 1'b0;
    localparam logic RW_WRITE  = 1'b1;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

endpackage

// File: rtl/mem_access_sequencer_arb.sv
// Grant decision between IF and MEM with a bounded MEM streak
// so a waiting instruction fetch cannot be starved.
module mem_seq_arb
    import mem_seq_pkg::*;
#(
    parameter int MEM_STREAK = 2
) (
    input  logic clk,
    input  logic R,
    input  logic if_req,
    input  logic mem_req,
    input  logic idle,
    output logic grant_valid,
    output logic grant_owner
);

    localparam int SW = (MEM_STREAK < 1) ? 1 : $clog2(MEM_STREAK + 1);

    logic [SW-1:0] r_streak;
    logic          w_mem_wins;

    assign w_mem_wins  = mem_req & (~if_req | (r_streak != SW'(MEM_STREAK)));
    assign grant_valid = idle & (if_req | mem_req);
    assign grant_owner = w_mem_wins ? OWN_MEM : OWN_IF;

    always_ff @(posedge clk) begin
        if (!R) begin
            r_streak <= '0;
        end else if (idle) begin
            if (!if_req)
                r_streak <= '0;
            else if (w_mem_wins)
                r_streak <= r_streak + 1'b1;
            else
                r_streak <= '0;
        end
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// Shares one byte-wide RAM port between IF and MEM, issuing each
// word as four big-endian byte beats and stalling until done.
module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int MEM_STREAK = 2
) (
    input  logic              clk,
    input  logic              R,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_rw,
    input  logic              mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              stall,
    output logic              ram_e,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_di,
    input  logic [7:0]        ram_do
);

    state_t            r_state;
    state_t            w_next;
    logic              r_owner;
    logic              r_rw;
    logic              r_size;
    logic [ADDR_W-1:0] r_base;
    logic [1:0]        r_cnt;
    logic [1:0]        r_last;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rbuf;
    logic [31:0]       r_if_rdata;
    logic [31:0]       r_mem_rdata;

    logic              w_idle;
    logic              w_grant_valid;
    logic              w_grant_owner;
    logic [7:0]        w_wlane;
    logic [31:0]       w_merged;
    logic [31:0]       w_resp;
    logic              w_last_beat;

    assign w_idle      = (r_state == IDLE);
    assign w_last_beat = (r_cnt == r_last);

    mem_seq_arb #(
        .MEM_STREAK(MEM_STREAK)
    ) u_arb (
        .clk        (clk),
        .R          (R),
        .if_req     (if_req),
        .mem_req    (mem_req),
        .idle       (w_idle),
        .grant_valid(w_grant_valid),
        .grant_owner(w_grant_owner)
    );

    // Lane i of the word sits at bits [31-8i : 24-8i]
    always_comb begin
        w_wlane  = r_wdata[31:24];
        w_merged = r_rbuf;
        unique case (r_cnt)
            2'd0: begin
                w_wlane         = r_wdata[31:24];
                w_merged[31:24] = ram_do;
            end
            2'd1: begin
                w_wlane         = r_wdata[23:16];
                w_merged[23:16] = ram_do;
            end
            2'd2: begin
                w_wlane         = r_wdata[15:8];
                w_merged[15:8]  = ram_do;
            end
            default: begin
                w_wlane         = r_wdata[7:0];
                w_merged[7:0]   = ram_do;
            end
        endcase
    end

    always_comb begin
        w_resp = '0;
        if (r_rw == RW_READ)
            w_resp = (r_size == SIZE_WORD) ? w_merged : {24'b0, ram_do};
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_grant_valid) w_next = BEAT;
            BEAT:    if (w_last_beat) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ram_e  = 1'b0;
        ram_rw = 1'b0;
        ram_a  = '0;
        ram_di = '0;
        if (r_state == BEAT) begin
            ram_e  = 1'b1;
            ram_rw = r_rw;
            ram_a  = r_base + ADDR_W'(r_cnt);
            ram_di = (r_size == SIZE_WORD) ? w_wlane : r_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!R) begin
            r_state     <= IDLE;
            r_owner     <= OWN_IF;
            r_rw        <= RW_READ;
            r_size      <= SIZE_BYTE;
            r_base      <= '0;
            r_cnt       <= '0;
            r_last      <= '0;
            r_wdata     <= '0;
            r_rbuf      <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_owner <= w_grant_owner;
                        r_cnt   <= '0;
                        r_rbuf  <= '0;
                        if (w_grant_owner == OWN_MEM) begin
                            r_base  <= mem_addr;
                            r_rw    <= mem_rw;
                            r_size  <= mem_size;
                            r_wdata <= mem_wdata;
                            r_last  <= mem_size ? 2'd3 : 2'd0;
                        end else begin
                            r_base  <= if_addr;
                            r_rw    <= RW_READ;
                            r_size  <= SIZE_WORD;
                            r_wdata <= '0;
                            r_last  <= 2'd3;
                        end
                    end
                end
                BEAT: begin
                    r_rbuf <= w_merged;
                    if (w_last_beat) begin
                        if (r_owner == OWN_IF)
                            r_if_rdata <= w_resp;
                        else
                            r_mem_rdata <= w_resp;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_done   = (r_state == RESP) & (r_owner == OWN_IF);
    assign mem_done  = (r_state == RESP) & (r_owner == OWN_MEM);
    assign if_rdata  = r_if_rdata;
    assign mem_rdata = r_mem_rdata;
    assign stall     = (if_req & ~if_done) | (mem_req & ~mem_done);

endmodule
